// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Function : Multi-cycle SRAM access controller that freezes the pipeline
//            while a load or store completes. Optional per-direction access
//            counters are enabled with macro MEM_ACCESS_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
   parameter int          WAIT_CYCLES = 5,
   parameter logic [31:0] ADDR_BASE   = 32'd1024,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_res,
   input  logic [31:0]        val_rm,
   output logic               ready,
   output logic [31:0]        rdata,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata,
   output logic               sram_we_n,
`ifdef MEM_ACCESS_PERF_CNT_EN
   output logic               sram_oe_n,
   output logic [31:0]        rd_cnt,
   output logic [31:0]        wr_cnt
`else
   output logic               sram_oe_n
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [3:0]    cnt_d;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          we_n_q;
   logic          oe_n_q;
   logic          w_req;
   logic [31:0]   w_offset;
   logic          w_unused;

   assign w_req = mem_r_en | mem_w_en;
   assign cnt_d = cnt_q + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_req) begin
                  // A simultaneous load and store is resolved as a store.
                  wr_q    <= mem_w_en;
                  addr_q  <= alu_res;
                  wdata_q <= val_rm;
                  cnt_q   <= 4'd0;
                  we_n_q  <= ~mem_w_en;
                  oe_n_q  <= mem_w_en;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (cnt_q == C_LAST) begin
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  state_q <= DONE;
                  if (!wr_q) begin
                     rdata_q <= sram_rdata;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               we_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_PERF_CNT_EN
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else if (state_q == WAIT && cnt_q == C_LAST) begin
         if (wr_q) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
         end else begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
         end
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

   // Word address relative to the SRAM window; low addresses wrap silently.
   assign w_offset   = addr_q - ADDR_BASE;
   assign sram_addr  = w_offset[SRAM_AW+1:2];
   assign w_unused   = ^{w_offset[31:SRAM_AW+2], w_offset[1:0]};

   assign sram_wdata = wdata_q;
   assign sram_we_n  = we_n_q;
   assign sram_oe_n  = oe_n_q;
   assign rdata      = rdata_q;
   assign ready      = (state_q == DONE) || ((state_q == IDLE) && !w_req);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Function : Scoreboard bench for mem_access_ctrl with a small SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   localparam int W = 5;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_res;
   logic [31:0] val_rm;
   logic        ready;
   logic [31:0] rdata;
   logic [17:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_we_n;
   logic        sram_oe_n;
`ifdef MEM_ACCESS_PERF_CNT_EN
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;
`endif

   mem_access_ctrl #(
      .WAIT_CYCLES (W),
      .ADDR_BASE   (32'd1024),
      .SRAM_AW     (18)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .alu_res    (alu_res),
      .val_rm     (val_rm),
      .ready      (ready),
      .rdata      (rdata),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_we_n  (sram_we_n),
`ifdef MEM_ACCESS_PERF_CNT_EN
      .sram_oe_n  (sram_oe_n),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
`else
      .sram_oe_n  (sram_oe_n)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tiny SRAM: only the low four word-address bits select a location.
   logic [31:0] mem [0:15];
   initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;
   always @(posedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_wdata;
   assign sram_rdata = mem[sram_addr[3:0]];

   typedef struct {
      logic [31:0] rdata;
      logic [17:0] addr;
      logic [31:0] wdata;
      bit          is_wr;
      int          we_c;
      int          oe_c;
      int          low_c;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: accumulates strobe/freeze cycles and checks at each DONE.
   int          m_we, m_oe, m_low;
   logic [17:0] m_addr;
   logic [31:0] m_wd;
   initial begin
      m_we = 0; m_oe = 0; m_low = 0; m_addr = '0; m_wd = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_we = 0; m_oe = 0; m_low = 0;
         end else begin
            if (!sram_we_n) begin m_we++; m_addr = sram_addr; m_wd = sram_wdata; end
            if (!sram_oe_n) begin m_oe++; m_addr = sram_addr; end
            if (!ready) m_low++;
            else if (m_low > 0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("rdata", rdata, e.rdata);
                  chk("sram_addr", 32'(m_addr), 32'(e.addr));
                  chk("we_cycles", 32'(m_we), 32'(e.we_c));
                  chk("oe_cycles", 32'(m_oe), 32'(e.oe_c));
                  chk("ready_low_cycles", 32'(m_low), 32'(e.low_c));
                  if (e.is_wr) chk("sram_wdata", m_wd, e.wdata);
               end
               m_we = 0; m_oe = 0; m_low = 0;
            end
         end
      end
   end

   // Issue one request (optionally held for reps back-to-back accesses).
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [17:0] exp_addr,
                            input logic [31:0] exp_rd, input int reps, input bit scramble);
      int   dones;
      int   cyc;
      bit   seen_low;
      exp_t e;
      e.rdata = exp_rd;  e.addr = exp_addr; e.wdata = data; e.is_wr = wr;
      e.we_c  = wr ? W : 0;
      e.oe_c  = (rd && !wr) ? W : 0;
      e.low_c = W + 1;
      for (int i = 0; i < reps; i++) exp_q.push_back(e);
      @(posedge clk); #1;
      mem_r_en = rd; mem_w_en = wr; alu_res = addr; val_rm = data;
      dones = 0; cyc = 0; seen_low = 0;
      while (dones < reps && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (scramble && cyc == 3) begin
            alu_res = 32'hFFFF_FFF0; val_rm = 32'd0; mem_w_en = 1'b0; mem_r_en = 1'b1;
         end
         if (!ready) seen_low = 1;
         else if (seen_low) begin dones++; seen_low = 0; end
      end
      if (dones < reps) chk("access_timeout", 32'(dones), 32'(reps));
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
   endtask

   initial begin
      rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; val_rm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'h3FF00);
      @(posedge clk); #1 rst = 1'b1;

      do_access(0, 1, 32'd1028, 32'hDEADBEEF, 18'd1, 32'd0,        1, 0);
      do_access(1, 0, 32'd1028, 32'd0,        18'd1, 32'hDEADBEEF, 1, 0);
      do_access(1, 1, 32'd1032, 32'h12345678, 18'd2, 32'hDEADBEEF, 1, 0);
      do_access(1, 0, 32'd1032, 32'd0,        18'd2, 32'h12345678, 1, 0);

      // Abort a store in its third WAIT cycle.
      @(posedge clk); #1;
      mem_w_en = 1'b1; alu_res = 32'd1040; val_rm = 32'h55;
      repeat (4) @(negedge clk);
      chk("abort_we_active", 32'(sram_we_n), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
      chk("abort_rdata", rdata, 32'd0);
      mem_w_en = 1'b0;
      #1 chk("abort_ready", 32'(ready), 32'd1);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("post_rst_ready", 32'(ready), 32'd1);

      do_access(1, 0, 32'd1028, 32'd0,        18'd1,       32'hDEADBEEF, 1, 0);
      do_access(0, 1, 32'd1020, 32'hCAFEF00D, 18'h3FFFF,   32'hDEADBEEF, 2, 0);
      do_access(1, 0, 32'd1020, 32'd0,        18'h3FFFF,   32'hCAFEF00D, 1, 0);
      do_access(0, 1, 32'd1036, 32'h0BADC0DE, 18'd3,       32'hCAFEF00D, 1, 1);
      do_access(1, 0, 32'd1036, 32'd0,        18'd3,       32'h0BADC0DE, 1, 0);

      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEM_ACCESS_PERF_CNT_EN
      chk("wr_cnt", wr_cnt, 32'd3);
      chk("rd_cnt", rd_cnt, 32'd3);
      #1 rst = 1'b0;
      #1;
      chk("wr_cnt_rst", wr_cnt, 32'd0);
      chk("rd_cnt_rst", rd_cnt, 32'd0);
      @(posedge clk); #1 rst = 1'b1;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
